time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
- Upstream stage of the clock datapath: turns raw push-buttons into a time-setting FSM.
- Edits hour/min/sec starting from the current time, then issues a one-cycle load to the time counter.
- Drives a field-select and blink flag so the FND path can flash the field being edited.
- Runs on the system clock, not the divided clock.

Parameters:
- DEBOUNCE_CYCLES, 20'd500000, consecutive stable samples needed before a button level is accepted (10 ms at 50 MHz)
- BLINK_HALF, 25'd12500000, cycles per blink half-period (0.25 s)
- REPEAT_DELAY, 26'd25000000, hold time before auto-repeat starts (AUTO_REPEAT_EN only)
- REPEAT_PERIOD, 24'd5000000, auto-repeat interval (AUTO_REPEAT_EN only)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_btn_mode  in  1  raw mode button, active-high, asynchronous
- i_btn_up  in  1  raw increment button, active-high, asynchronous
- i_btn_down  in  1  raw decrement button, active-high, asynchronous
- i_hour  in  7  current hour, 0-23
- i_min  in  7  current minute, 0-59
- i_sec  in  7  current second, 0-59
- o_hour  out  7  edited hour
- o_min  out  7  edited minute
- o_sec  out  7  edited second
- o_load  out  1  one-cycle pulse: counter loads o_hour/o_min/o_sec
- o_setting  out  1  high while in any SET state
- o_field  out  2  0=none, 1=hour, 2=min, 3=sec
- o_blink  out  1  blink phase; 1 = blank the selected field

Behaviour:
- Reset (i_reset=0, async): FSM=RUN; o_hour/o_min/o_sec=0; o_load=0; o_setting=0; o_field=0; o_blink=0; debouncers cleared to level 0.
- Button conditioning, identical for each button:
  - 2-FF synchroniser feeding a counter.
  - The debounced level changes only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle clears the counter.
  - Press pulse = 1 cycle on the debounced 0→1 edge.
  - Latency from a stable raw edge to the pulse = DEBOUNCE_CYCLES+3 cycles.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC.
  - RUN + mode pulse → SET_HOUR; the same edge captures i_hour/i_min/i_sec into the edit registers.
  - SET_HOUR + mode → SET_MIN.
  - SET_MIN + mode → SET_SEC.
  - SET_SEC + mode → RUN, with o_load=1 for exactly the first cycle in RUN.
- Editing (SET states only):
  - up pulse: selected field +1 (hour 23→0, min/sec 59→0).
  - down pulse: selected field −1 (0→23 or 0→59).
  - Other fields are unchanged.
- Simultaneous events:
  - mode+up or mode+down in the same cycle: mode is taken, up/down dropped.
  - up+down in the same cycle: both ignored.
- In RUN, up/down are ignored and the edit registers hold their last values.
- o_setting=1 and o_field=1/2/3 in SET_HOUR/SET_MIN/SET_SEC; o_setting=0 and o_field=0 in RUN.
- Blink:
  - A counter restarts at 0 with o_blink=0 on every SET state entry and on every up/down edit.
  - o_blink toggles every BLINK_HALF cycles.
  - o_blink is forced 0 in RUN.
- Out-of-range capture inputs (e.g. i_min=60) are clamped to the field maximum on capture.
- Reset mid-edit aborts the edit: return to RUN, no o_load.

Optional Feature:
- Macro: TIME_SET_AUTO_REPEAT_EN.
- Defined:
  - Holding the debounced up or down for REPEAT_DELAY cycles generates an extra step pulse.
  - Further pulses follow every REPEAT_PERIOD cycles while held.
  - Release, mode pulse or state change stops repeat and clears the counters.
  - If both up and down are held, there is no repeat.
- Undefined: one step per press only; the repeat counters and parameters are unused and no logic is generated.

Decomposition:
- Shared package time_clock_pkg:
  - state enum (RUN, SET_HOUR, SET_MIN, SET_SEC) as 2-bit localparams;
  - field codes FIELD_NONE/HOUR/MIN/SEC;
  - HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59;
  - TIME_W=7.
- One sub-module, btn_debounce (sync + counter + edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times.
- FSM, wrap arithmetic and blink stay in time_set_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_HALF=8, REPEAT_DELAY=16, REPEAT_PERIOD=4):
- Mode bounce: 1-cycle glitches on i_btn_mode, then held high 10 cycles → exactly one transition RUN→SET_HOUR; o_field=1; o_setting=1.
- Capture: i_hour=12, i_min=34, i_sec=56, then one mode press → o_hour=12, o_min=34, o_sec=56.
- Hour wrap: in SET_HOUR with hour=23, one up press → 0; one down press → 23.
- Minute wrap: in SET_MIN with min=0, one down press → 59.
- Full edit: three mode presses after editing → o_load high exactly 1 cycle, o_field=0, o_blink=0.
- Conflicts:
  - mode and up debounced on the same cycle → state advances, field value unchanged.
  - i_reset low during SET_MIN → RUN, o_load never asserted.
  - With TIME_SET_AUTO_REPEAT_EN: hold up for 16+12 cycles in SET_SEC from 58 → steps 59, 0, 1, 2.

Source files
------------

// File: rtl/time_clock_pkg.sv
// Shared types, field codes and wrap helpers for the clock datapath.
package time_clock_pkg;

    localparam int unsigned TIME_W = 7;

    // FSM states; SET state codes line up with the field codes below
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StSetHour = 2'd1,
        StSetMin  = 2'd2,
        StSetSec  = 2'd3
    } state_e;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam logic [TIME_W-1:0] HOUR_MAX = 7'd23;
    localparam logic [TIME_W-1:0] MIN_MAX  = 7'd59;
    localparam logic [TIME_W-1:0] SEC_MAX  = 7'd59;

    function automatic logic [TIME_W-1:0] clamp_field(input logic [TIME_W-1:0] v,
                                                      input logic [TIME_W-1:0] max);
        return (v > max) ? max : v;
    endfunction

    function automatic logic [TIME_W-1:0] inc_wrap(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] max);
        return (v >= max) ? '0 : v + TIME_W'(1);
    endfunction

    function automatic logic [TIME_W-1:0] dec_wrap(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] max);
        return (v == '0) ? max : v - TIME_W'(1);
    endfunction

endpackage

// File: rtl/time_set_ctrl_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, registered press pulse.
// Press pulse appears DEBOUNCE_CYCLES+3 cycles after a stable raw edge.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q, sync2_q;
    logic             level_q, level_dly_q, press_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the raw asynchronous button into the clock domain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching samples
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    // One-cycle pulse on the debounced rising edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting FSM: debounced buttons edit hour/min/sec, then load the time counter.
// Optional auto-repeat on held up/down is enabled by defining TIME_SET_AUTO_REPEAT_EN.
module time_set_ctrl
    import time_clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned BLINK_HALF      = 12500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_btn_mode,
    input  logic              i_btn_up,
    input  logic              i_btn_down,
    input  logic [TIME_W-1:0] i_hour,
    input  logic [TIME_W-1:0] i_min,
    input  logic [TIME_W-1:0] i_sec,
    output logic [TIME_W-1:0] o_hour,
    output logic [TIME_W-1:0] o_min,
    output logic [TIME_W-1:0] o_sec,
    output logic              o_load,
    output logic              o_setting,
    output logic [1:0]        o_field,
    output logic              o_blink
);

    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic mode_level, up_level, down_level;
    logic mode_press, up_press, down_press;
    logic step_up, step_down;

    state_e              state_q;
    logic [TIME_W-1:0]   hour_q, min_q, sec_q;
    logic                load_q, setting_q, blink_q;
    logic [1:0]          field_q;
    logic [BLINK_W-1:0]  blink_cnt_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
        .clk_i   (i_clk),
        .rst_ni  (i_reset),
        .btn_i   (i_btn_mode),
        .level_o (mode_level),
        .press_o (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk_i   (i_clk),
        .rst_ni  (i_reset),
        .btn_i   (i_btn_up),
        .level_o (up_level),
        .press_o (up_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk_i   (i_clk),
        .rst_ni  (i_reset),
        .btn_i   (i_btn_down),
        .level_o (down_level),
        .press_o (down_press)
    );

    logic unused_levels;

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    logic             rep_hold, rep_armed_q, rep_pulse_q;
    logic [REP_W-1:0] rep_cnt_q;

    // Exactly one of up/down held in a SET state; a mode press ends the hold
    assign rep_hold = (state_q != StRun) && (up_level != down_level) && !mode_press;

    // Repeat timer: first extra step after REPEAT_DELAY, then every REPEAT_PERIOD
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
            rep_pulse_q <= 1'b0;
        end else if (!rep_hold) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
            rep_pulse_q <= 1'b0;
        end else begin
            rep_pulse_q <= 1'b0;
            rep_cnt_q   <= rep_cnt_q + REP_W'(1);
            if (!rep_armed_q && rep_cnt_q == REP_W'(REPEAT_DELAY - 1)) begin
                rep_pulse_q <= 1'b1;
                rep_armed_q <= 1'b1;
                rep_cnt_q   <= '0;
            end else if (rep_armed_q && rep_cnt_q == REP_W'(REPEAT_PERIOD - 1)) begin
                rep_pulse_q <= 1'b1;
                rep_cnt_q   <= '0;
            end
        end
    end

    // Gate with the level so a pulse landing on release is dropped
    assign step_up       = up_press | (rep_pulse_q & up_level);
    assign step_down     = down_press | (rep_pulse_q & down_level);
    assign unused_levels = mode_level;
`else
    assign step_up       = up_press;
    assign step_down     = down_press;
    assign unused_levels = mode_level ^ up_level ^ down_level ^
                           (REPEAT_DELAY == REPEAT_PERIOD);
`endif

    // Mode advances the FSM (and wins over edits); up/down edit the selected field
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= StRun;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            load_q      <= 1'b0;
            setting_q   <= 1'b0;
            field_q     <= FIELD_NONE;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            load_q <= 1'b0;
            if (mode_press) begin
                blink_cnt_q <= '0;
                blink_q     <= 1'b0;
                case (state_q)
                    StRun: begin
                        state_q   <= StSetHour;
                        field_q   <= FIELD_HOUR;
                        setting_q <= 1'b1;
                        hour_q    <= clamp_field(i_hour, HOUR_MAX);
                        min_q     <= clamp_field(i_min, MIN_MAX);
                        sec_q     <= clamp_field(i_sec, SEC_MAX);
                    end
                    StSetHour: begin
                        state_q <= StSetMin;
                        field_q <= FIELD_MIN;
                    end
                    StSetMin: begin
                        state_q <= StSetSec;
                        field_q <= FIELD_SEC;
                    end
                    default: begin
                        state_q   <= StRun;
                        field_q   <= FIELD_NONE;
                        setting_q <= 1'b0;
                        load_q    <= 1'b1;
                    end
                endcase
            end else if (state_q != StRun) begin
                if (step_up != step_down) begin
                    blink_cnt_q <= '0;
                    blink_q     <= 1'b0;
                    case (state_q)
                        StSetHour: hour_q <= step_up ? inc_wrap(hour_q, HOUR_MAX)
                                                     : dec_wrap(hour_q, HOUR_MAX);
                        StSetMin:  min_q  <= step_up ? inc_wrap(min_q, MIN_MAX)
                                                     : dec_wrap(min_q, MIN_MAX);
                        default:   sec_q  <= step_up ? inc_wrap(sec_q, SEC_MAX)
                                                     : dec_wrap(sec_q, SEC_MAX);
                    endcase
                end else if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
                    blink_cnt_q <= '0;
                    blink_q     <= ~blink_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
                end
            end
        end
    end

    assign o_hour    = hour_q;
    assign o_min     = min_q;
    assign o_sec     = sec_q;
    assign o_load    = load_q;
    assign o_setting = setting_q;
    assign o_field   = field_q;
    assign o_blink   = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomised self-checking bench for time_set_ctrl against an event-level model.
module tb_time_set_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned BH  = 8;
    localparam int unsigned RD  = 16;
    localparam int unsigned RP  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       b_mode = 1'b0, b_up = 1'b0, b_down = 1'b0;
    logic [6:0] in_h = '0, in_m = '0, in_s = '0;
    logic [6:0] o_h, o_m, o_s;
    logic       o_load, o_setting, o_blink;
    logic [1:0] o_field;

    int n_checks = 0;
    int n_errors = 0;

    // Model: state 0=RUN,1=hour,2=min,3=sec; edit values; expected load count
    int m_state = 0, m_h = 0, m_m = 0, m_s = 0, m_loads = 0;
    int load_seen = 0, load_run = 0, load_max = 0;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .BLINK_HALF      (BH),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_btn_mode (b_mode),
        .i_btn_up   (b_up),
        .i_btn_down (b_down),
        .i_hour     (in_h),
        .i_min      (in_m),
        .i_sec      (in_s),
        .o_hour     (o_h),
        .o_min      (o_m),
        .o_sec      (o_s),
        .o_load     (o_load),
        .o_setting  (o_setting),
        .o_field    (o_field),
        .o_blink    (o_blink)
    );

    always @(negedge clk) begin
        if (o_load) begin
            load_seen = load_seen + 1;
            load_run  = load_run + 1;
            if (load_run > load_max) load_max = load_run;
        end else begin
            load_run = 0;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_press(input bit m, input bit u, input bit d);
        if (m) begin
            case (m_state)
                0: begin
                    m_state = 1;
                    m_h = (in_h > 23) ? 23 : int'(in_h);
                    m_m = (in_m > 59) ? 59 : int'(in_m);
                    m_s = (in_s > 59) ? 59 : int'(in_s);
                end
                1: m_state = 2;
                2: m_state = 3;
                default: begin
                    m_state = 0;
                    m_loads++;
                end
            endcase
        end else if (m_state != 0 && u != d) begin
            case (m_state)
                1: m_h = u ? (m_h + 1) % 24 : (m_h + 23) % 24;
                2: m_m = u ? (m_m + 1) % 60 : (m_m + 59) % 60;
                default: m_s = u ? (m_s + 1) % 60 : (m_s + 59) % 60;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_hour"}, int'(o_h), m_h);
        check_eq({tag, "_min"}, int'(o_m), m_m);
        check_eq({tag, "_sec"}, int'(o_s), m_s);
        check_eq({tag, "_field"}, int'(o_field), m_state);
        check_eq({tag, "_setting"}, int'(o_setting), (m_state != 0) ? 1 : 0);
        check_eq({tag, "_loads"}, load_seen, m_loads);
        if (m_state == 0) check_eq({tag, "_blink_run"}, int'(o_blink), 0);
    endtask

    // Clean press: raw buttons held 8 cycles, then released long enough to settle
    task automatic press(input bit m, input bit u, input bit d);
        b_mode = m; b_up = u; b_down = d;
        cycles(8);
        b_mode = 1'b0; b_up = 1'b0; b_down = 1'b0;
        cycles(12);
        model_press(m, u, d);
    endtask

    task automatic glitch(input int which);
        for (int k = 0; k < 3; k++) begin
            case (which)
                0: b_mode = 1'b1;
                1: b_up = 1'b1;
                default: b_down = 1'b1;
            endcase
            cycles($urandom_range(1, 3));
            b_mode = 1'b0; b_up = 1'b0; b_down = 1'b0;
            cycles($urandom_range(1, 3));
        end
        cycles(10);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check_eq("rst_async_field", int'(o_field), 0);
        check_eq("rst_async_hour", int'(o_h), 0);
        check_eq("rst_async_setting", int'(o_setting), 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        m_state = 0; m_h = 0; m_m = 0; m_s = 0;
    endtask

    initial begin
        int lat, w, ones_a, ones_b, op;
        logic [6:0] prev;

        // Reset state
        cycles(3);
        check_eq("rst_hour", int'(o_h), 0);
        check_eq("rst_min", int'(o_m), 0);
        check_eq("rst_sec", int'(o_s), 0);
        check_eq("rst_load", int'(o_load), 0);
        check_eq("rst_setting", int'(o_setting), 0);
        check_eq("rst_field", int'(o_field), 0);
        check_eq("rst_blink", int'(o_blink), 0);
        rst_n = 1'b1;
        cycles(2);

        // Mode bounce, then a clean 10-cycle hold with capture of 12:34:56
        in_h = 7'd12; in_m = 7'd34; in_s = 7'd56;
        glitch(0);
        check_eq("bounce_no_change", int'(o_field), 0);
        b_mode = 1'b1;
        lat = 0;
        while (o_field == 2'd0 && lat < 50) begin
            cycles(1);
            lat++;
        end
        check_eq("mode_latency", lat, int'(DEB) + 4);
        cycles(10 - lat > 0 ? 10 - lat : 0);
        b_mode = 1'b0;
        cycles(12);
        model_press(1'b1, 1'b0, 1'b0);
        check_all("capture");

        // Blink restarts on an edit: 8 cycles low, then 8 high, then low
        prev = o_h;
        b_up = 1'b1;
        w = 0;
        while (o_h == prev && w < 50) begin
            cycles(1);
            w++;
        end
        b_up = 1'b0;
        ones_a = int'(o_blink);
        for (int i = 1; i < int'(BH); i++) begin
            cycles(1);
            ones_a += int'(o_blink);
        end
        ones_b = 0;
        for (int i = 0; i < int'(BH); i++) begin
            cycles(1);
            ones_b += int'(o_blink);
        end
        check_eq("blink_low_phase", ones_a, 0);
        check_eq("blink_high_phase", ones_b, int'(BH));
        cycles(1);
        check_eq("blink_toggle_back", int'(o_blink), 0);
        cycles(12);
        model_press(1'b0, 1'b1, 1'b0);
        check_all("blink_edit");

        // Hour wrap both ways
        while (m_h != 23) press(1'b0, 1'b1, 1'b0);
        check_all("hour_23");
        press(1'b0, 1'b1, 1'b0);
        check_eq("hour_wrap_up", int'(o_h), 0);
        press(1'b0, 1'b0, 1'b1);
        check_eq("hour_wrap_down", int'(o_h), 23);

        // Mode and up together: mode wins, hour untouched
        press(1'b1, 1'b1, 1'b0);
        check_all("mode_up_conflict");

        // Minute wrap down from 0
        while (m_m != 0) press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        check_eq("min_wrap_down", int'(o_m), 59);

        // Up and down together are ignored
        press(1'b0, 1'b1, 1'b1);
        check_all("up_down_conflict");

        // Finish the edit: single load pulse, back to RUN
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check_all("full_edit");

        // Reset in SET_MIN aborts without a load
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check_all("enter_set_min");
        do_reset();
        check_all("reset_mid_edit");

`ifdef TIME_SET_AUTO_REPEAT_EN
        begin
            int vals[$];
            in_h = 7'd0; in_m = 7'd0; in_s = 7'd58;
            press(1'b1, 1'b0, 1'b0);
            press(1'b1, 1'b0, 1'b0);
            press(1'b1, 1'b0, 1'b0);
            check_all("repeat_setup");
            prev = o_s;
            b_up = 1'b1;
            for (int i = 0; i < int'(RD) + 12 + 20; i++) begin
                if (i == int'(RD) + 12) b_up = 1'b0;
                cycles(1);
                if (o_s != prev) begin
                    vals.push_back(int'(o_s));
                    prev = o_s;
                end
            end
            check_eq("repeat_count", vals.size(), 4);
            while (vals.size() < 4) vals.push_back(-1);
            check_eq("repeat_0", vals[0], 59);
            check_eq("repeat_1", vals[1], 0);
            check_eq("repeat_2", vals[2], 1);
            check_eq("repeat_3", vals[3], 2);
            m_s = 2;
            press(1'b1, 1'b0, 1'b0);
            check_all("repeat_done");
        end
`endif

        // Randomised operation mix
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 10);
            case (op)
                0, 1, 2: press(1'b1, 1'b0, 1'b0);
                3, 4:    press(1'b0, 1'b1, 1'b0);
                5, 6:    press(1'b0, 1'b0, 1'b1);
                7:       press(1'b0, 1'b1, 1'b1);
                8: begin
                    w = $urandom_range(0, 1);
                    press(1'b1, w[0], ~w[0]);
                end
                9: begin
                    glitch($urandom_range(0, 2));
                    in_h = 7'($urandom_range(0, 127));
                    in_m = 7'($urandom_range(0, 127));
                    in_s = 7'($urandom_range(0, 127));
                end
                default: do_reset();
            endcase
            check_all("rand");
        end

        check_eq("load_width", load_max, (m_loads > 0) ? 1 : 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
